mcu_test_ctrl: RTL and testbench

Synthesizable end-of-test controller for the pipelined MCU. It sits beside the core and its data memory, and it detects test completion by one of three events: a write to a tohost address, a stalled fetch PC, or a watchdog timeout. It then halts the core and sweeps the DFM against a golden memory image, one word per cycle. It reports the pass/fail result, the error count and the first mismatch index, so the same check runs in simulation and on FPGA without a fixed run time.

---
 rtl/mcu_test_ctrl_pkg.sv | 36 +++
 rtl/mcu_end_detect.sv | 72 +++++++
 rtl/mcu_test_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_mcu_test_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_test_ctrl_pkg.sv
// Shared types for the end-of-test controller: FSM states, end causes and the
// priority rule used when several end events fire in the same cycle.
package pkg_mcu_test;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_CMP   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'd0,
      CAUSE_TOHOST   = 2'd1,
      CAUSE_PC_STALL = 2'd2,
      CAUSE_TIMEOUT  = 2'd3
   } end_cause_t;

   localparam int DRAIN_CYCLES = 2;

   function automatic end_cause_t pick_cause(input logic tohost_hit,
                                             input logic stall_hit,
                                             input logic timeout_hit);
      if (tohost_hit) begin
         return CAUSE_TOHOST;
      end else if (stall_hit) begin
         return CAUSE_PC_STALL;
      end else if (timeout_hit) begin
         return CAUSE_TIMEOUT;
      end else begin
         return CAUSE_NONE;
      end
   endfunction

endpackage

// File: rtl/mcu_end_detect.sv
// End-event detector: watchdog, fetch-PC stall counter and tohost write match,
// combined into one end event with a prioritised cause.
module mcu_end_detect
   import pkg_mcu_test::*;
#(
   parameter int                        ADDR_BUS_WIDTH  = 32,
   parameter int                        TIMEOUT_CYCLES  = 2000,
   parameter int                        PC_STALL_CYCLES = 16,
   parameter logic [ADDR_BUS_WIDTH-1:0] TOHOST_ADDR     = 32'h1000_0FFC
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst_n,
   input  logic                      clr,
   input  logic                      run,
   input  logic [ADDR_BUS_WIDTH-1:0] pfm_req_addr,
   input  logic [ADDR_BUS_WIDTH-1:0] cpu_req_addr,
   input  logic                      cpu_wr_en,
   output logic                      end_evt,
   output logic [1:0]                cause
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int ST_W = $clog2(PC_STALL_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ST_W-1:0] ST_MAX  = ST_W'(PC_STALL_CYCLES);

   logic [WD_W-1:0]           wdog_q, wdog_d;
   logic [ST_W-1:0]           stall_q, stall_d;
   logic [ADDR_BUS_WIDTH-1:0] prev_pc_q;
   logic                      pc_same_s, tohost_hit_s, stall_hit_s, timeout_hit_s;

   // Next counter values and the three raw end events.
   always_comb begin
      wdog_d    = wdog_q;
      stall_d   = stall_q;
      pc_same_s = (pfm_req_addr == prev_pc_q);
      if (clr) begin
         wdog_d  = '0;
         stall_d = '0;
      end else if (run) begin
         wdog_d = (wdog_q == WD_MAX) ? wdog_q : wdog_q + WD_W'(1);
         if (!pc_same_s) begin
            stall_d = '0;
         end else begin
            stall_d = (stall_q == ST_MAX) ? stall_q : stall_q + ST_W'(1);
         end
      end else begin
         wdog_d  = wdog_q;
         stall_d = stall_q;
      end
      tohost_hit_s  = run && cpu_wr_en && (cpu_req_addr == TOHOST_ADDR);
      stall_hit_s   = run && (stall_d == ST_MAX);
      timeout_hit_s = run && (wdog_q == WD_LAST);
      end_evt       = tohost_hit_s || stall_hit_s || timeout_hit_s;
      cause         = pick_cause(tohost_hit_s, stall_hit_s, timeout_hit_s);
   end

   // Counter and previous-PC registers.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wdog_q    <= '0;
         stall_q   <= '0;
         prev_pc_q <= '0;
      end else begin
         wdog_q    <= wdog_d;
         stall_q   <= stall_d;
         prev_pc_q <= pfm_req_addr;
      end
   end

endmodule

// File: rtl/mcu_test_ctrl.sv
// End-of-test controller: waits for an end event, halts the core, drains stores,
// then sweeps the DFM against the gold image and reports the result.
module mcu_test_ctrl
   import pkg_mcu_test::*;
#(
   parameter int                        ADDR_BUS_WIDTH  = 32,
   parameter int                        DATA_BUS_WIDTH  = 32,
   parameter int                        CMP_DEPTH       = 1024,
   parameter int                        TIMEOUT_CYCLES  = 2000,
   parameter int                        PC_STALL_CYCLES = 16,
   parameter logic [ADDR_BUS_WIDTH-1:0] TOHOST_ADDR     = 32'h1000_0FFC
) (
   input  logic                           sys_clk,
   input  logic                           sys_rst_n,
   input  logic                           start,
   input  logic [ADDR_BUS_WIDTH-1:0]      pfm_req_addr,
   input  logic [ADDR_BUS_WIDTH-1:0]      cpu_req_addr,
   input  logic                           cpu_wr_en,
   input  logic [DATA_BUS_WIDTH-1:0]      cpu_wr_data,
   output logic                           cpu_halt,
   output logic                           cmp_rd_en,
   output logic [$clog2(CMP_DEPTH)-1:0]   cmp_idx,
   input  logic [DATA_BUS_WIDTH-1:0]      dfm_cmp_data,
   input  logic [DATA_BUS_WIDTH-1:0]      gold_cmp_data,
   output logic                           done,
   output logic                           pass,
   output logic [1:0]                     end_cause,
   output logic [DATA_BUS_WIDTH-1:0]      tohost_val,
   output logic [$clog2(CMP_DEPTH):0]     err_count,
   output logic [$clog2(CMP_DEPTH)-1:0]   first_err_idx
);

   localparam int IDX_W = $clog2(CMP_DEPTH);
   localparam int CNT_W = IDX_W + 1;
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(CMP_DEPTH - 1);
   localparam logic [CNT_W-1:0] ERR_MAX    = CNT_W'(CMP_DEPTH);
   localparam logic [1:0]       DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

   state_t                    state_q, state_d;
   logic [1:0]                drain_q, drain_d;
   logic                      cpu_halt_q, cpu_halt_d;
   logic                      rd_en_q, rd_en_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic                      vld_q, vld_d;
   logic [IDX_W-1:0]          vld_idx_q, vld_idx_d;
   logic                      done_q, done_d;
   logic                      pass_q, pass_d;
   end_cause_t                end_cause_q, end_cause_d;
   logic [DATA_BUS_WIDTH-1:0] tohost_val_q, tohost_val_d;
   logic [CNT_W-1:0]          err_count_q, err_count_d;
   logic [IDX_W-1:0]          first_err_idx_q, first_err_idx_d;
   logic                      clr_s, run_s, end_evt_s, mismatch_s;
   logic [1:0]                cause_s;

   assign clr_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign run_s = (state_q == ST_RUN);

   mcu_end_detect #(
      .ADDR_BUS_WIDTH  (ADDR_BUS_WIDTH),
      .TIMEOUT_CYCLES  (TIMEOUT_CYCLES),
      .PC_STALL_CYCLES (PC_STALL_CYCLES),
      .TOHOST_ADDR     (TOHOST_ADDR)
   ) u_end_detect (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .clr          (clr_s),
      .run          (run_s),
      .pfm_req_addr (pfm_req_addr),
      .cpu_req_addr (cpu_req_addr),
      .cpu_wr_en    (cpu_wr_en),
      .end_evt      (end_evt_s),
      .cause        (cause_s)
   );

   // FSM next state, read sequencer and compare pipeline.
   always_comb begin
      state_d         = state_q;
      drain_d         = drain_q;
      cpu_halt_d      = cpu_halt_q;
      rd_en_d         = rd_en_q;
      idx_d           = idx_q;
      vld_d           = rd_en_q;
      vld_idx_d       = idx_q;
      done_d          = done_q;
      pass_d          = pass_q;
      end_cause_d     = end_cause_q;
      tohost_val_d    = tohost_val_q;
      err_count_d     = err_count_q;
      first_err_idx_d = first_err_idx_q;
      // 4-state inequality so an X word in simulation counts as a mismatch.
      mismatch_s      = vld_q && (dfm_cmp_data !== gold_cmp_data);
      if (mismatch_s) begin
         err_count_d     = (err_count_q == ERR_MAX) ? err_count_q : err_count_q + CNT_W'(1);
         first_err_idx_d = (err_count_q == '0) ? vld_idx_q : first_err_idx_q;
      end else begin
         err_count_d     = err_count_q;
         first_err_idx_d = first_err_idx_q;
      end
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (clr_s) begin
               state_d         = ST_RUN;
               cpu_halt_d      = 1'b0;
               rd_en_d         = 1'b0;
               idx_d           = '0;
               done_d          = 1'b0;
               pass_d          = 1'b0;
               end_cause_d     = CAUSE_NONE;
               tohost_val_d    = '0;
               err_count_d     = '0;
               first_err_idx_d = '0;
            end else begin
               state_d = state_q;
            end
         end
         ST_RUN: begin
            if (end_evt_s) begin
               state_d      = ST_DRAIN;
               drain_d      = 2'd0;
               cpu_halt_d   = 1'b1;
               end_cause_d  = end_cause_t'(cause_s);
               tohost_val_d = (end_cause_t'(cause_s) == CAUSE_TOHOST) ? cpu_wr_data : tohost_val_q;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (drain_q == DRAIN_LAST) begin
               state_d = ST_CMP;
               rd_en_d = 1'b1;
               idx_d   = '0;
            end else begin
               drain_d = drain_q + 2'd1;
            end
         end
         ST_CMP: begin
            if (rd_en_q && (idx_q == IDX_LAST)) begin
               rd_en_d = 1'b0;
            end else if (rd_en_q) begin
               idx_d = idx_q + IDX_W'(1);
            end else begin
               rd_en_d = 1'b0;
            end
            if (vld_q && (vld_idx_q == IDX_LAST)) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               pass_d  = (err_count_d == '0) && (end_cause_q != CAUSE_TIMEOUT);
            end else begin
               state_d = ST_CMP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // All state and output registers.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q         <= ST_IDLE;
         drain_q         <= 2'd0;
         cpu_halt_q      <= 1'b0;
         rd_en_q         <= 1'b0;
         idx_q           <= '0;
         vld_q           <= 1'b0;
         vld_idx_q       <= '0;
         done_q          <= 1'b0;
         pass_q          <= 1'b0;
         end_cause_q     <= CAUSE_NONE;
         tohost_val_q    <= '0;
         err_count_q     <= '0;
         first_err_idx_q <= '0;
      end else begin
         state_q         <= state_d;
         drain_q         <= drain_d;
         cpu_halt_q      <= cpu_halt_d;
         rd_en_q         <= rd_en_d;
         idx_q           <= idx_d;
         vld_q           <= vld_d;
         vld_idx_q       <= vld_idx_d;
         done_q          <= done_d;
         pass_q          <= pass_d;
         end_cause_q     <= end_cause_d;
         tohost_val_q    <= tohost_val_d;
         err_count_q     <= err_count_d;
         first_err_idx_q <= first_err_idx_d;
      end
   end

   assign cpu_halt      = cpu_halt_q;
   assign cmp_rd_en     = rd_en_q;
   assign cmp_idx       = idx_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign end_cause     = end_cause_q;
   assign tohost_val    = tohost_val_q;
   assign err_count     = err_count_q;
   assign first_err_idx = first_err_idx_q;

endmodule

// File: tb/tb_mcu_test_ctrl.sv
// Bench for mcu_test_ctrl: directed vector table plus randomized runs, checked
// against a cycle-level model of the end rules and a memory-diff reference.
module tb_mcu_test_ctrl;

   localparam int          D   = 1024;
   localparam int          TO  = 2000;
   localparam int          STL = 16;
   localparam int          IW  = 10;
   localparam int          CW  = 11;
   localparam logic [31:0] TH  = 32'h1000_0FFC;

   logic          sys_clk, sys_rst_n, start, cpu_wr_en;
   logic          cpu_halt, cmp_rd_en, done, pass;
   logic [31:0]   pfm_req_addr, cpu_req_addr, cpu_wr_data;
   logic [31:0]   dfm_cmp_data, gold_cmp_data, tohost_val;
   logic [IW-1:0] cmp_idx, first_err_idx;
   logic [CW-1:0] err_count;
   logic [1:0]    end_cause;

   logic [31:0] dfm_mem  [D];
   logic [31:0] gold_mem [D];

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      int          mode;
      int          evt;
      logic [31:0] thd;
      int          c0;
      int          c1;
      bit          xw0;
      bit          use_model;
      logic [1:0]  e_cause;
      logic        e_pass;
      int          e_err;
      int          e_first;
      logic [31:0] e_th;
      int          e_end;
   } vec_t;

   mcu_test_ctrl #(
      .ADDR_BUS_WIDTH  (32),
      .DATA_BUS_WIDTH  (32),
      .CMP_DEPTH       (D),
      .TIMEOUT_CYCLES  (TO),
      .PC_STALL_CYCLES (STL),
      .TOHOST_ADDR     (TH)
   ) dut (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .start         (start),
      .pfm_req_addr  (pfm_req_addr),
      .cpu_req_addr  (cpu_req_addr),
      .cpu_wr_en     (cpu_wr_en),
      .cpu_wr_data   (cpu_wr_data),
      .cpu_halt      (cpu_halt),
      .cmp_rd_en     (cmp_rd_en),
      .cmp_idx       (cmp_idx),
      .dfm_cmp_data  (dfm_cmp_data),
      .gold_cmp_data (gold_cmp_data),
      .done          (done),
      .pass          (pass),
      .end_cause     (end_cause),
      .tohost_val    (tohost_val),
      .err_count     (err_count),
      .first_err_idx (first_err_idx)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Synchronous-read memories: data follows the read strobe by one cycle.
   always @(posedge sys_clk) begin
      if (cmp_rd_en) begin
         dfm_cmp_data  <= dfm_mem[cmp_idx];
         gold_cmp_data <= gold_mem[cmp_idx];
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [63:0] outs_vec();
      return {27'd0, cpu_halt, cmp_rd_en, cmp_idx, done, pass, end_cause, err_count, first_err_idx};
   endfunction

   // Per-cycle core activity for each scenario kind; noise writes never hit tohost.
   task automatic stim(input int mode, input int evt, input logic [31:0] thd, input int k,
                       output logic [31:0] pc, output logic wr,
                       output logic [31:0] addr, output logic [31:0] data);
      pc   = 32'h100 + 32'(4 * k);
      wr   = 1'b0;
      addr = 32'h2000;
      data = $urandom;
      if ($urandom_range(0, 7) == 0) begin
         wr   = 1'b1;
         addr = TH - 32'(4 * $urandom_range(1, 64));
      end else if ($urandom_range(0, 7) == 0) begin
         addr = TH;
      end
      case (mode)
         0: if (k == evt) begin wr = 1'b1; addr = TH; data = thd; end
         1: if (k >= evt) pc = 32'h40;
         3: begin
            pc = 32'h40;
            if (k == evt) begin wr = 1'b1; addr = TH; data = thd; end
         end
         4: pc = 32'h200 + 32'(4 * (k / evt));
         default: ;
      endcase
   endtask

   task automatic do_run(input int mode, input int evt, input logic [31:0] thd,
                         output logic [1:0] m_cause, output logic [31:0] m_th,
                         output int m_end, output int dut_end);
      logic [31:0] pc, pc_prev, addr, data;
      logic        wr;
      int          run_len, k, bad, done_j;
      bit          ended, exp_rd;
      bad = 0; run_len = 0; ended = 0; k = 0; done_j = 0;
      m_cause = 2'd0; m_th = 32'd0; dut_end = 0;
      stim(mode, evt, thd, 0, pc, wr, addr, data);
      pc_prev      = pc;
      pfm_req_addr = pc;
      cpu_wr_en    = 1'b0;
      start        = 1'b1;
      @(posedge sys_clk); #1;
      start = 1'b0;
      check("restart_clear", outs_vec() | {32'd0, tohost_val}, 64'd0);
      while (!ended) begin
         k++;
         stim(mode, evt, thd, k, pc, wr, addr, data);
         pfm_req_addr = pc;
         cpu_wr_en    = wr;
         cpu_req_addr = addr;
         cpu_wr_data  = data;
         start        = (k == 2);
         run_len      = (pc == pc_prev) ? run_len + 1 : 0;
         pc_prev      = pc;
         if (wr && addr == TH) begin m_cause = 2'd1; m_th = data; ended = 1; end
         else if (run_len >= STL) begin m_cause = 2'd2; ended = 1; end
         else if (k >= TO) begin m_cause = 2'd3; ended = 1; end
         @(posedge sys_clk); #1;
         start     = 1'b0;
         cpu_wr_en = 1'b0;
         if (cpu_halt === 1'b1 && dut_end == 0) dut_end = k;
         if (cpu_halt !== ended) bad++;
         if (cmp_rd_en !== 1'b0) bad++;
      end
      m_end = k;
      for (int j = 1; j <= D + 5; j++) begin
         start = (j == 1 || j == 20);
         @(posedge sys_clk); #1;
         start  = 1'b0;
         exp_rd = (j >= 2 && j <= D + 1);
         if (cmp_rd_en !== exp_rd) bad++;
         if (exp_rd && cmp_idx !== IW'(j - 2)) bad++;
         if (cpu_halt !== 1'b1) bad++;
         if (done === 1'b1 && done_j == 0) done_j = j;
         if (done_j != 0 && done !== 1'b1) bad++;
      end
      check("sweep_sequence", bad, 0);
      check("done_latency", done_j, D + 3);
   endtask

   task automatic run_case(input vec_t v, input bit rnd);
      int          merr, mfirst, m_end, dut_end;
      logic [1:0]  m_cause;
      logic [31:0] m_th;
      logic        mpass;
      for (int i = 0; i < D; i++) begin
         gold_mem[i] = $urandom;
         dfm_mem[i]  = gold_mem[i];
      end
      if (v.c0 >= 0) dfm_mem[v.c0] = ~gold_mem[v.c0];
      if (v.c1 >= 0) dfm_mem[v.c1] = ~gold_mem[v.c1];
      if (v.xw0) begin
         gold_mem[0] = 32'd0;
         dfm_mem[0]  = 'x;
      end
      merr = 0; mfirst = 0;
      for (int i = 0; i < D; i++) begin
         if (dfm_mem[i] !== gold_mem[i]) begin
            if (merr == 0) mfirst = i;
            merr++;
         end
      end
      do_run(v.mode, v.evt, v.thd, m_cause, m_th, m_end, dut_end);
      mpass = (merr == 0) && (m_cause != 2'd3);
      check("end_cycle",  dut_end,    rnd ? m_end   : v.e_end);
      check("end_cause",  end_cause,  rnd ? m_cause : v.e_cause);
      check("tohost_val", tohost_val, rnd ? m_th    : v.e_th);
      if (rnd || v.use_model) begin
         check("err_count",     err_count,     merr);
         check("first_err_idx", first_err_idx, mfirst);
         check("pass",          pass,          mpass);
      end else begin
         check("err_count",     err_count,     v.e_err);
         check("first_err_idx", first_err_idx, v.e_first);
         check("pass",          pass,          v.e_pass);
      end
   endtask

   initial begin
      vec_t vecs [6];
      vec_t rv;
      vecs[0] = '{0, 100, 32'h1,         -1,   -1,   1'b0, 1'b0, 2'd1, 1'b1, 0, 0,    32'h1,         100};
      vecs[1] = '{1, 30,  32'h0,         5,    700,  1'b0, 1'b0, 2'd2, 1'b0, 2, 5,    32'h0,         46};
      vecs[2] = '{2, 0,   32'h0,         -1,   -1,   1'b0, 1'b0, 2'd3, 1'b0, 0, 0,    32'h0,         TO};
      vecs[3] = '{3, 16,  32'hCAFE_0001, -1,   -1,   1'b0, 1'b0, 2'd1, 1'b1, 0, 0,    32'hCAFE_0001, 16};
      vecs[4] = '{0, 20,  32'h7,         -1,   -1,   1'b1, 1'b1, 2'd1, 1'b0, 1, 0,    32'h7,         20};
      vecs[5] = '{1, 3,   32'h0,         1023, 1000, 1'b0, 1'b0, 2'd2, 1'b0, 2, 1000, 32'h0,         19};

      sys_rst_n    = 1'b0;
      start        = 1'b0;
      cpu_wr_en    = 1'b0;
      pfm_req_addr = 32'd0;
      cpu_req_addr = 32'd0;
      cpu_wr_data  = 32'd0;
      for (int i = 0; i < D; i++) begin
         gold_mem[i] = 32'h0;
         dfm_mem[i]  = 32'h0;
      end
      #23;
      check("reset_vals",   outs_vec(), 64'd0);
      check("reset_tohost", tohost_val, 64'd0);
      @(posedge sys_clk); #1;
      sys_rst_n = 1'b1;

      // Reset while the sweep is in progress.
      start        = 1'b1;
      pfm_req_addr = 32'h100;
      @(posedge sys_clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         pfm_req_addr = 32'h100 + 32'(4 * k);
         cpu_wr_en    = (k == 5);
         cpu_req_addr = TH;
         cpu_wr_data  = 32'h5;
         @(posedge sys_clk); #1;
      end
      cpu_wr_en = 1'b0;
      repeat (100) @(posedge sys_clk);
      #1;
      check("mid_cmp_active", {cpu_halt, cmp_rd_en, end_cause}, {1'b1, 1'b1, 2'd1});
      #2 sys_rst_n = 1'b0;
      #1;
      check("async_halt_release", cpu_halt,   64'd0);
      check("async_reset_vals",   outs_vec(), 64'd0);
      check("async_reset_tohost", tohost_val, 64'd0);
      @(posedge sys_clk); #1;
      sys_rst_n = 1'b1;
      repeat (5) @(posedge sys_clk);
      #1;
      check("idle_after_reset", {cpu_halt, done, cmp_rd_en}, 64'd0);

      for (int t = 0; t < 6; t++) run_case(vecs[t], 1'b0);

      for (int r = 0; r < 4; r++) begin
         rv           = vecs[0];
         rv.mode      = int'($urandom_range(0, 4));
         rv.evt       = int'($urandom_range(3, 300));
         rv.thd       = $urandom;
         rv.c0        = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, D - 1)) : -1;
         rv.c1        = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, D - 1)) : -1;
         rv.xw0       = 1'b0;
         rv.use_model = 1'b1;
         run_case(rv, 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
